// File: rtl/pgr_fft_out_ctrl.sv
// pgr_fft_out_ctrl
// Output-side controller of the burst FFT/IFFT core. A single-cycle
// fft_cdone starts a burst: the result RAM is read in natural or bit-reversed
// order and the samples leave on an AXI-stream-style master port with full
// backpressure. A 4-entry FIFO absorbs the fixed 2-cycle RAM read latency.
// Reads are only issued while the reads still in the latency pipe plus the
// FIFO occupancy stay below 4, so the FIFO can never overflow.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   fft_cdone                    start pulse, accepted only while idle
//   dft_length                   sample count minus 1 (latched on start)
//   fft_lev_limit                log2 transform size (latched and clamped)
//   rd_en, rd_addr               result RAM read strobe / address
//   rd_data_re, rd_data_im       RAM data, valid 2 cycles after rd_en
//   m_axi_valid/ready/last       output handshake, last marks index == length
//   m_axi_data_re/im, m_axi_index  output sample and its index
//   fft_odone                    one-cycle pulse after the last handshake
//   busy                         high while a burst is in progress
module pgr_fft_out_ctrl #(
   parameter int DATA_WIDTH = 18,
   parameter int ADDR_WIDTH = 9,
   parameter int LEN_WIDTH  = 16,
   parameter bit BIT_REV    = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         fft_cdone,
   input  logic [LEN_WIDTH-1:0]         dft_length,
   input  logic [3:0]                   fft_lev_limit,
   output logic                         rd_en,
   output logic [ADDR_WIDTH-1:0]        rd_addr,
   input  logic signed [DATA_WIDTH-1:0] rd_data_re,
   input  logic signed [DATA_WIDTH-1:0] rd_data_im,
   output logic                         m_axi_valid,
   input  logic                         m_axi_ready,
   output logic                         m_axi_last,
   output logic signed [DATA_WIDTH-1:0] m_axi_data_re,
   output logic signed [DATA_WIDTH-1:0] m_axi_data_im,
   output logic [LEN_WIDTH-1:0]         m_axi_index,
   output logic                         fft_odone,
   output logic                         busy
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   // Largest address width representable by the 4-bit level field.
   localparam logic [4:0] W_MAX = 5'((ADDR_WIDTH > 15) ? 15 : ADDR_WIDTH);

   state_t                  state_q, state_d;
   logic [LEN_WIDTH-1:0]    len_q, len_d;
   logic [LEN_WIDTH-1:0]    rk_q, rk_d;
   logic [LEN_WIDTH-1:0]    ok_q, ok_d;
   logic [4:0]              w_q, w_d;
   logic                    vld_p1_q, vld_p1_d;
   logic                    vld_p2_q, vld_p2_d;
   logic [2:0]              fifo_cnt_q, fifo_cnt_d;
   logic [1:0]              wptr_q, wptr_d;
   logic [1:0]              rptr_q, rptr_d;
   logic                    odone_q, odone_d;

   logic signed [DATA_WIDTH-1:0] mem_re_q [4];
   logic signed [DATA_WIDTH-1:0] mem_im_q [4];

   logic                    issue;
   logic                    push;
   logic                    pop;
   logic                    fifo_vld;
   logic                    last_hs;
   logic [2:0]              credit;
   logic [ADDR_WIDTH-1:0]   addr_sel;

   // Reverse all address bits, then shift so only the low w bits of k
   // end up reversed in the low w bits of the result (w = 0 gives 0).
   function automatic logic [ADDR_WIDTH-1:0] rev_addr(
      input logic [ADDR_WIDTH-1:0] k,
      input logic [4:0]            w
   );
      logic [ADDR_WIDTH-1:0] r;
      for (int i = 0; i < ADDR_WIDTH; i++) begin
         r[i] = k[ADDR_WIDTH-1-i];
      end
      return r >> (ADDR_WIDTH - int'(w));
   endfunction

   always_comb begin
      credit   = {2'b00, vld_p1_q} + {2'b00, vld_p2_q} + fifo_cnt_q;
      issue    = (state_q == S_RUN) && (credit < 3'd4);
      fifo_vld = (fifo_cnt_q != 3'd0);
      push     = vld_p2_q;
      pop      = fifo_vld && m_axi_ready;
      last_hs  = pop && (ok_q == len_q) && (state_q == S_DRAIN);
      addr_sel = BIT_REV ? rev_addr(rk_q[ADDR_WIDTH-1:0], w_q)
                         : rk_q[ADDR_WIDTH-1:0];
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      w_d        = w_q;
      rk_d       = rk_q;
      ok_d       = pop ? ok_q + LEN_WIDTH'(1) : ok_q;
      vld_p1_d   = issue;
      vld_p2_d   = vld_p1_q;
      fifo_cnt_d = fifo_cnt_q + {2'b00, push} - {2'b00, pop};
      wptr_d     = push ? wptr_q + 2'd1 : wptr_q;
      rptr_d     = pop ? rptr_q + 2'd1 : rptr_q;
      odone_d    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (fft_cdone) begin
               len_d      = dft_length;
               w_d        = ({1'b0, fft_lev_limit} > W_MAX) ? W_MAX
                                                            : {1'b0, fft_lev_limit};
               rk_d       = '0;
               ok_d       = '0;
               vld_p1_d   = 1'b0;
               vld_p2_d   = 1'b0;
               fifo_cnt_d = '0;
               wptr_d     = '0;
               rptr_d     = '0;
               state_d    = S_RUN;
            end
         end
         S_RUN: begin
            if (issue) begin
               rk_d = rk_q + LEN_WIDTH'(1);
               if (rk_q == len_q) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (last_hs) begin
               state_d = S_IDLE;
               odone_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         w_q        <= '0;
         rk_q       <= '0;
         ok_q       <= '0;
         vld_p1_q   <= 1'b0;
         vld_p2_q   <= 1'b0;
         fifo_cnt_q <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         odone_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         w_q        <= w_d;
         rk_q       <= rk_d;
         ok_q       <= ok_d;
         vld_p1_q   <= vld_p1_d;
         vld_p2_q   <= vld_p2_d;
         fifo_cnt_q <= fifo_cnt_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         odone_q    <= odone_d;
      end
   end

   // RAM data arrives together with vld_p2 and goes straight into the FIFO.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_re_q[wptr_q] <= rd_data_re;
         mem_im_q[wptr_q] <= rd_data_im;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(push && !pop && (fifo_cnt_q == 3'd4)));
      end
   end

   assign rd_en         = issue;
   assign rd_addr       = issue ? addr_sel : '0;
   assign m_axi_valid   = fifo_vld;
   assign m_axi_last    = fifo_vld && (ok_q == len_q);
   assign m_axi_data_re = fifo_vld ? mem_re_q[rptr_q] : '0;
   assign m_axi_data_im = fifo_vld ? mem_im_q[rptr_q] : '0;
   assign m_axi_index   = ok_q;
   assign fft_odone     = odone_q;
   assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_pgr_fft_out_ctrl.sv
module tb_pgr_fft_out_ctrl;

   localparam int DW = 18;
   localparam int AW = 9;
   localparam int LW = 16;
   localparam bit BR = 1'b1;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 fft_cdone;
   logic [LW-1:0]        dft_length;
   logic [3:0]           fft_lev_limit;
   logic                 rd_en;
   logic [AW-1:0]        rd_addr;
   logic signed [DW-1:0] rd_data_re;
   logic signed [DW-1:0] rd_data_im;
   logic                 m_axi_valid;
   logic                 m_axi_ready;
   logic                 m_axi_last;
   logic signed [DW-1:0] m_axi_data_re;
   logic signed [DW-1:0] m_axi_data_im;
   logic [LW-1:0]        m_axi_index;
   logic                 fft_odone;
   logic                 busy;

   int checks = 0;
   int errors = 0;
   int salt   = 0;
   int rmode  = 0;

   pgr_fft_out_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .BIT_REV(BR)) dut (
      .clk(clk), .rst_n(rst_n), .fft_cdone(fft_cdone), .dft_length(dft_length),
      .fft_lev_limit(fft_lev_limit), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data_re(rd_data_re), .rd_data_im(rd_data_im), .m_axi_valid(m_axi_valid),
      .m_axi_ready(m_axi_ready), .m_axi_last(m_axi_last), .m_axi_data_re(m_axi_data_re),
      .m_axi_data_im(m_axi_data_im), .m_axi_index(m_axi_index), .fft_odone(fft_odone),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // RAM contents as a function of address and a per-burst salt.
   function automatic logic signed [DW-1:0] ram_re(input int a, input int s);
      return DW'(a * 37 + s);
   endfunction
   function automatic logic signed [DW-1:0] ram_im(input int a, input int s);
      return DW'(a * 5 - s);
   endfunction

   // Address the k-th read must use.
   function automatic int exp_addr(input int k, input int w);
      int a;
      if (!BR) return k & ((1 << AW) - 1);
      a = 0;
      for (int b = 0; b < w; b++) begin
         if (((k >> b) & 1) != 0) a |= (1 << (w - 1 - b));
      end
      return a;
   endfunction

   // RAM emulation: data shows up exactly 2 cycles after the read strobe,
   // random junk otherwise.
   initial begin
      logic          e0, e1;
      logic [AW-1:0] a0, a1;
      e1 = 1'b0; a1 = '0;
      rd_data_re = '0; rd_data_im = '0;
      forever begin
         @(posedge clk);
         e0 = rd_en; a0 = rd_addr;
         #1;
         if (e1) begin
            rd_data_re = ram_re(int'(a1), salt);
            rd_data_im = ram_im(int'(a1), salt);
         end else begin
            rd_data_re = DW'($urandom);
            rd_data_im = DW'($urandom);
         end
         e1 = e0; a1 = a0;
      end
   end

   // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
   initial begin
      int phase;
      phase = 0;
      m_axi_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            1: begin
               case (phase % 4)
                  0: m_axi_ready = 1'b1;
                  1: m_axi_ready = 1'b0;
                  2: m_axi_ready = 1'b0;
                  default: m_axi_ready = 1'b1;
               endcase
               phase++;
            end
            2: m_axi_ready = 1'($urandom_range(0, 1));
            default: m_axi_ready = 1'b1;
         endcase
      end
   end

   // Behavioural model state.
   int   l_m = 0, w_m = 0, salt_m = 0, rk_m = 0, ok_m = 0;
   bit   busy_m = 0, odone_exp = 0;
   int   cyc = 0;
   int   first_rd_cyc = -1, first_beat_cyc = -1, last_hs_cyc = -1, odone_cyc = -1;
   int   nlast = 0, n_odone = 0;
   int   addr_log [64];
   logic signed [DW-1:0] beat_re_log [64];
   logic signed [DW-1:0] beat_im_log [64];
   bit   prev_stall = 0;
   logic signed [DW-1:0] prev_re, prev_im;
   logic [LW-1:0] prev_idx;
   logic prev_last;

   // Compare process: every cycle, away from the active edge.
   initial begin
      bit busy_nxt, odone_nxt;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_rd_en", rd_en, 0);
            chk("rst_rd_addr", rd_addr, 0);
            chk("rst_valid", m_axi_valid, 0);
            chk("rst_last", m_axi_last, 0);
            chk("rst_odone", fft_odone, 0);
            chk("rst_busy", busy, 0);
            chk("rst_data_re", m_axi_data_re, 0);
            chk("rst_data_im", m_axi_data_im, 0);
            chk("rst_index", m_axi_index, 0);
            busy_m = 0; odone_exp = 0; prev_stall = 0;
         end else begin
            cyc++;
            chk("busy", busy, busy_m);
            chk("odone", fft_odone, odone_exp);
            if (fft_odone) begin
               odone_cyc = cyc;
               n_odone++;
            end
            busy_nxt = busy_m; odone_nxt = 0;

            if (rd_en) begin
               chk("rd_allowed", (busy_m && rk_m <= l_m) ? 1 : 0, 1);
               chk("rd_addr", rd_addr, exp_addr(rk_m, w_m));
               chk("credit", (rk_m - ok_m) < 4 ? 1 : 0, 1);
               if (first_rd_cyc < 0) first_rd_cyc = cyc;
               if (rk_m < 64) addr_log[rk_m] = int'(rd_addr);
               rk_m++;
            end

            if (prev_stall) begin
               chk("hold_valid", m_axi_valid, 1);
               chk("hold_re", m_axi_data_re, prev_re);
               chk("hold_im", m_axi_data_im, prev_im);
               chk("hold_idx", m_axi_index, prev_idx);
               chk("hold_last", m_axi_last, prev_last);
            end

            if (m_axi_valid) begin
               chk("beat_allowed", (busy_m && ok_m <= l_m) ? 1 : 0, 1);
               chk("beat_index", m_axi_index, ok_m);
               chk("beat_last", m_axi_last, (ok_m == l_m) ? 1 : 0);
               chk("beat_re", m_axi_data_re, ram_re(exp_addr(ok_m, w_m), salt_m));
               chk("beat_im", m_axi_data_im, ram_im(exp_addr(ok_m, w_m), salt_m));
               if (first_beat_cyc < 0) first_beat_cyc = cyc;
            end

            prev_stall = m_axi_valid && !m_axi_ready;
            prev_re = m_axi_data_re; prev_im = m_axi_data_im;
            prev_idx = m_axi_index;  prev_last = m_axi_last;

            if (m_axi_valid && m_axi_ready) begin
               if (ok_m < 64) begin
                  beat_re_log[ok_m] = m_axi_data_re;
                  beat_im_log[ok_m] = m_axi_data_im;
               end
               if (m_axi_last) nlast++;
               if (ok_m == l_m) begin
                  busy_nxt = 0; odone_nxt = 1; last_hs_cyc = cyc;
               end
               ok_m++;
            end

            if (!busy_m && fft_cdone) begin
               l_m = int'(dft_length);
               w_m = (int'(fft_lev_limit) > AW) ? AW : int'(fft_lev_limit);
               salt_m = salt; rk_m = 0; ok_m = 0; busy_nxt = 1; cyc = 0;
               first_rd_cyc = -1; first_beat_cyc = -1; last_hs_cyc = -1;
               odone_cyc = -1; nlast = 0;
            end
            busy_m = busy_nxt; odone_exp = odone_nxt;
         end
      end
   end

   task automatic start(input int len, input int lev);
      @(posedge clk); #1;
      fft_cdone = 1'b1; dft_length = LW'(len); fft_lev_limit = 4'(lev);
      @(posedge clk); #1;
      fft_cdone = 1'b0; dft_length = LW'($urandom); fft_lev_limit = 4'($urandom);
   endtask

   task automatic wait_odone(input int budget);
      bit seen;
      seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (fft_odone) begin
            seen = 1;
            break;
         end
      end
      chk("odone_seen", seen, 1);
      #1;
   endtask

   initial begin
      int od0;
      int addr_exp [8];
      addr_exp = '{0, 4, 2, 6, 1, 5, 3, 7};
      rst_n = 1'b0; fft_cdone = 1'b0; dft_length = '0; fft_lev_limit = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // N=8, ready high: timing and bit-reversed order pinned by hand.
      rmode = 0; salt = 100;
      start(7, 3);
      wait_odone(100);
      chk("A_first_rd", first_rd_cyc, 1);
      chk("A_first_beat", first_beat_cyc, 4);
      chk("A_last_hs", last_hs_cyc, 11);
      chk("A_odone", odone_cyc, 12);
      chk("A_nlast", nlast, 1);
      for (int i = 0; i < 8; i++) chk("A_addr", addr_log[i], addr_exp[i]);
      chk("A_beat1_re", beat_re_log[1], 248);
      chk("A_beat1_im", beat_im_log[1], -80);

      // N=16 with ready 1,0,0,1.
      rmode = 1; salt = int'($urandom_range(0, 5000));
      od0 = n_odone;
      start(15, 4);
      wait_odone(400);
      chk("B_beats", ok_m, 16);
      chk("B_odone_cnt", n_odone - od0, 1);

      // Second start mid-RUN must be ignored.
      rmode = 2; salt = int'($urandom_range(0, 5000));
      start(20, 5);
      repeat (4) @(posedge clk);
      #1 fft_cdone = 1'b1; dft_length = LW'(3);
      @(posedge clk); #1 fft_cdone = 1'b0;
      wait_odone(400);
      chk("C_beats", ok_m, 21);

      // L=0 started in the cycle after fft_odone.
      rmode = 0;
      start(0, 3);
      wait_odone(100);
      chk("D_last_hs", last_hs_cyc, 4);
      chk("D_odone", odone_cyc, 5);
      chk("D_nlast", nlast, 1);
      chk("D_beat0_re", beat_re_log[0], ram_re(0, salt));

      // Level 12 clamps to 9 address bits.
      rmode = 2; salt = int'($urandom_range(0, 5000));
      start(40, 12);
      wait_odone(800);
      chk("E_addr1", addr_log[1], 256);
      chk("E_addr3", addr_log[3], 384);

      // Long burst wrapping the address space.
      salt = int'($urandom_range(0, 5000));
      start(600, 2);
      wait_odone(6000);
      chk("F_beats", ok_m, 601);

      // Reset while beat 5 of 8 is presented.
      rmode = 0; salt = 7;
      od0 = n_odone;
      start(7, 3);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (ok_m >= 5) break;
      end
      chk("G_reached5", ok_m, 5);
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      chk("G_valid", m_axi_valid, 0);
      chk("G_busy", busy, 0);
      chk("G_index", m_axi_index, 0);
      chk("G_data", m_axi_data_re, 0);
      chk("G_last", m_axi_last, 0);
      repeat (3) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("G_no_odone", n_odone - od0, 0);

      // Clean burst after the reset.
      rmode = 2; salt = int'($urandom_range(0, 5000));
      start(7, 3);
      wait_odone(200);
      chk("H_beats", ok_m, 8);
      chk("H_nlast", nlast, 1);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
